// File: rtl/burst_pi_pkg.sv
// Shared types and helpers for the chroma burst PI loop filter.
// State encoding, widths and the signed clamp used by the datapath.
package burst_pi_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_AVG,
    S_PI,
    S_OUT
  } state_e;

  localparam int SAT_W = 96;
  localparam int CNT_W = 16;

  // Clamp to the symmetric range +/-(2^(n-1)-1).
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] v,
    input int                      n
  );
    logic signed [SAT_W-1:0] lim;
    lim = {{(SAT_W-1){1'b0}}, 1'b1};
    lim = lim <<< (n - 1);
    lim = lim - SAT_W'(1);
    if (v > lim)
      return lim;
    else if (v < -lim)
      return -lim;
    else
      return v;
  endfunction

endpackage

// File: rtl/burst_accumulator.sv
// Burst edge detect, saturating error accumulator and snapshot.
// A burst touched by freeze is discarded at its falling edge.
module burst_accumulator
  import burst_pi_pkg::*;
#(
  parameter int ERR_W = 12,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_burst,
  input  logic                    i_freeze,
  input  logic                    i_idle,
  input  logic signed [ERR_W-1:0] i_err,
  output logic                    o_snap,
  output logic signed [ACC_W-1:0] o_acc,
  output logic        [CNT_W-1:0] o_cnt
);

  logic                    r_burst_d;
  logic                    r_taint;
  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [ACC_W-1:0] r_snap_acc;
  logic        [CNT_W-1:0] r_snap_cnt;

  logic                    w_rise;
  logic                    w_fall;
  logic        [ACC_W-1:0] w_ext;
  logic        [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_acc_sat;
  logic        [CNT_W-1:0] w_cnt_inc;

  assign w_rise = i_burst & ~r_burst_d;
  assign w_fall = ~i_burst & r_burst_d;

  assign w_ext = {{(ACC_W-ERR_W){i_err[ERR_W-1]}}, i_err};
  assign w_sum = {w_ext[ACC_W-1], w_ext}
               + {r_acc[ACC_W-1], r_acc};

  always_comb begin
    w_acc_sat = w_sum[ACC_W-1:0];
    if (w_sum[ACC_W] != w_sum[ACC_W-1])
      w_acc_sat = w_sum[ACC_W]
                ? {1'b1, {(ACC_W-1){1'b0}}}
                : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt
                   : r_cnt + CNT_W'(1);

  assign o_snap = w_fall & ~i_freeze
                & ~r_taint & i_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst_d <= 1'b0;
      r_taint   <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
    end else begin
      r_burst_d <= i_burst;
      if (w_rise)
        r_taint <= i_freeze;
      else if (i_burst && i_freeze)
        r_taint <= 1'b1;
      if (!i_freeze) begin
        if (w_rise) begin
          r_acc <= $signed(w_ext);
          r_cnt <= CNT_W'(1);
        end else if (i_burst) begin
          r_acc <= w_acc_sat;
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap_acc <= '0;
      r_snap_cnt <= '0;
    end else if (o_snap) begin
      r_snap_acc <= r_acc;
      r_snap_cnt <= r_cnt;
    end
  end

  assign o_acc = r_snap_acc;
  assign o_cnt = r_snap_cnt;

endmodule

// File: rtl/burst_pi_loop_filter.sv
// PI loop filter for the chroma burst PLL: burst average, PI, NCO offset.
// Optional lock detector built when BURST_PI_LOCK_DETECT_EN is defined.
module burst_pi_loop_filter
  import burst_pi_pkg::*;
#(
  parameter int ERR_W       = 12,
  parameter int OUT_W       = 32,
  parameter int ACC_W       = 24,
  parameter int AVG_SHIFT   = 4,
  parameter int MIN_SAMPLES = 8,
  parameter int LOCK_THRESH = 64,
  parameter int LOCK_LINES  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    burst_active,
  input  logic signed [ERR_W-1:0] error_in,
  input  logic        [4:0]       kp_shift,
  input  logic        [4:0]       ki_shift,
  input  logic                    freeze,
  output logic signed [OUT_W-1:0] offset_out,
  output logic                    offset_valid,
  output logic                    sat_flag,
  output logic                    locked
);

  state_e r_state;
  state_e w_state_nxt;

  logic w_idle;
  logic w_ld_avg;
  logic w_ld_pi;
  logic w_ld_out;

  logic                    w_snap;
  logic signed [ACC_W-1:0] w_snap_acc;
  logic        [CNT_W-1:0] w_snap_cnt;
  logic                    w_cnt_ok;

  logic signed [ACC_W-1:0] r_err_avg;
  logic signed [OUT_W-1:0] r_integ;
  logic                    r_isat;
  logic signed [SAT_W-1:0] r_p;
  logic signed [OUT_W-1:0] r_offset;
  logic                    r_valid;
  logic                    r_sat;

  logic signed [SAT_W-1:0] w_iterm;
  logic signed [SAT_W-1:0] w_isum;
  logic signed [SAT_W-1:0] w_inext;
  logic signed [SAT_W-1:0] w_pterm;
  logic signed [SAT_W-1:0] w_osum;
  logic signed [SAT_W-1:0] w_onext;

  burst_accumulator #(
    .ERR_W (ERR_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .i_burst  (burst_active),
    .i_freeze (freeze),
    .i_idle   (w_idle),
    .i_err    (error_in),
    .o_snap   (w_snap),
    .o_acc    (w_snap_acc),
    .o_cnt    (w_snap_cnt)
  );

  assign w_cnt_ok = (w_snap_cnt >= CNT_W'(MIN_SAMPLES));

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_snap) w_state_nxt = S_AVG;
      S_AVG:  w_state_nxt = w_cnt_ok ? S_PI : S_IDLE;
      S_PI:   w_state_nxt = S_OUT;
      S_OUT:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_idle   = 1'b0;
    w_ld_avg = 1'b0;
    w_ld_pi  = 1'b0;
    w_ld_out = 1'b0;
    unique case (r_state)
      S_IDLE: w_idle   = 1'b1;
      S_AVG:  w_ld_avg = w_cnt_ok;
      S_PI:   w_ld_pi  = 1'b1;
      S_OUT:  w_ld_out = 1'b1;
    endcase
  end

  // All PI math runs in SAT_W bits so no shift of err_avg can overflow.
  assign w_iterm = SAT_W'(r_err_avg) <<< ki_shift;
  assign w_pterm = SAT_W'(r_err_avg) <<< kp_shift;
  assign w_isum  = SAT_W'(r_integ) + w_iterm;
  assign w_inext = sat_signed(w_isum, OUT_W);
  assign w_osum  = SAT_W'(r_integ) + r_p;
  assign w_onext = sat_signed(w_osum, OUT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_avg <= '0;
      r_integ   <= '0;
      r_isat    <= 1'b0;
      r_p       <= '0;
    end else begin
      if (w_ld_avg)
        r_err_avg <= w_snap_acc >>> AVG_SHIFT;
      if (w_ld_pi) begin
        r_integ <= OUT_W'(w_inext);
        r_isat  <= (w_inext != w_isum);
        r_p     <= w_pterm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_offset <= '0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_valid <= w_ld_out;
      if (w_ld_out) begin
        r_offset <= OUT_W'(w_onext);
        r_sat    <= r_isat | (w_onext != w_osum);
      end
    end
  end

  assign offset_out   = r_offset;
  assign offset_valid = r_valid;
  assign sat_flag     = r_sat;

`ifdef BURST_PI_LOCK_DETECT_EN
  localparam int LK_W = $clog2(LOCK_LINES + 1);

  logic [LK_W-1:0] r_lock_cnt;
  logic            r_locked;
  logic [LK_W-1:0] w_lock_nxt;
  logic            w_in_lock;

  assign w_in_lock =
    (r_err_avg <= $signed(ACC_W'(LOCK_THRESH))) &&
    (r_err_avg >= -$signed(ACC_W'(LOCK_THRESH)));

  assign w_lock_nxt =
    (r_lock_cnt == LK_W'(LOCK_LINES)) ? r_lock_cnt
                                      : r_lock_cnt + LK_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
    end else if (w_ld_out) begin
      if (w_in_lock) begin
        r_lock_cnt <= w_lock_nxt;
        r_locked   <= (w_lock_nxt == LK_W'(LOCK_LINES));
      end else begin
        r_lock_cnt <= '0;
        r_locked   <= 1'b0;
      end
    end
  end

  assign locked = r_locked;
`else
  assign locked = 1'b0;
`endif

endmodule
